// File: rtl/chacha_seq_ctrl.sv
// ChaCha block sequencer: steps the datapath through load, ARX rounds and final add,
// runs the 64-byte readout handshake and owns the 32-bit block counter.
module chacha_seq_ctrl #(
    parameter int ROUNDS    = 20,
    parameter int STEPS     = 4,
    parameter bit AUTO_NEXT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    input  logic        cfg_wr,
    input  logic        ctr_wr,
    input  logic [31:0] ctr_in,
    input  logic        rd_blk,
    output logic        ld_init,
    output logic        rnd_en,
    output logic        diag,
    output logic [1:0]  step,
    output logic        add_init,
    output logic        blk_ready,
    output logic [5:0]  rd_addr,
    output logic        rd_en,
    output logic [31:0] blk_ctr,
    output logic        ctr_ovf,
    output logic        busy
);

    localparam int            RW        = $clog2(ROUNDS + 1);
    localparam logic [RW-1:0] LAST_RND  = RW'(ROUNDS - 1);
    localparam logic [1:0]    LAST_STEP = 2'(STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_READY, S_READ, S_NEXT
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] round_cnt_q, round_cnt_d;
    logic [1:0]    step_q, step_d;
    logic [5:0]    rd_addr_q, rd_addr_d;
    logic [31:0]   blk_ctr_q, blk_ctr_d;
    logic          ctr_ovf_q, ctr_ovf_d;
    logic          ld_init_q, ld_init_d;
    logic          rnd_en_q, rnd_en_d;
    logic          add_init_q, add_init_d;
    logic          blk_ready_q, blk_ready_d;
    logic          rd_en_q, rd_en_d;
    logic          busy_q, busy_d;

    logic computing, abort, freeze;

    always_comb begin
        computing   = state_q inside {S_LOAD, S_ROUND, S_FINAL};
        // A counter rewrite mid-block would leave the datapath with a stale counter.
        abort       = computing && (cfg_wr || (ctr_wr && (ctr_in != blk_ctr_q)));
        freeze      = computing && hold && !abort;

        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        step_d      = step_q;
        blk_ctr_d   = blk_ctr_q;
        ctr_ovf_d   = ctr_ovf_q;

        if (state_q == S_NEXT) begin
            blk_ctr_d = blk_ctr_q + 32'd1;
            if (blk_ctr_q == 32'hFFFF_FFFF) begin
                ctr_ovf_d = 1'b1;
            end
        end
        if (ctr_wr) begin
            blk_ctr_d = ctr_in;
            ctr_ovf_d = 1'b0;
        end

        if (!freeze) begin
            unique case (state_q)
                S_IDLE:  if (start && !cfg_wr) state_d = S_LOAD;
                S_LOAD:  state_d = abort ? S_IDLE : S_ROUND;
                S_ROUND: begin
                    if (abort) begin
                        state_d = S_IDLE;
                    end else if (step_q == LAST_STEP) begin
                        step_d = 2'd0;
                        if (round_cnt_q == LAST_RND) begin
                            state_d = S_FINAL;
                        end else begin
                            round_cnt_d = round_cnt_q + RW'(1);
                        end
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
                S_FINAL: state_d = abort ? S_IDLE : S_READY;
                S_READY: begin
                    if (cfg_wr)      state_d = S_IDLE;
                    else if (rd_blk) state_d = S_READ;
                end
                S_READ: begin
                    if (cfg_wr)                  state_d = S_IDLE;
                    else if (rd_addr_q == 6'd63) state_d = S_NEXT;
                end
                S_NEXT:  state_d = (AUTO_NEXT && !ctr_ovf_d && !cfg_wr) ? S_LOAD : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Round position only has meaning inside ROUND; every entry starts from zero.
        if (state_d != S_ROUND) begin
            round_cnt_d = '0;
            step_d      = 2'd0;
        end

        rd_addr_d   = (state_q == S_READ && state_d == S_READ) ? rd_addr_q + 6'd1 : 6'd0;

        ld_init_d   = (state_d == S_LOAD)  && !freeze;
        rnd_en_d    = (state_d == S_ROUND) && !freeze;
        add_init_d  = (state_d == S_FINAL) && !freeze;
        blk_ready_d = (state_d == S_READY);
        rd_en_d     = (state_d == S_READ);
        busy_d      = !(state_d inside {S_IDLE, S_READY});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            round_cnt_q <= '0;
            step_q      <= 2'd0;
            rd_addr_q   <= 6'd0;
            blk_ctr_q   <= 32'd0;
            ctr_ovf_q   <= 1'b0;
            ld_init_q   <= 1'b0;
            rnd_en_q    <= 1'b0;
            add_init_q  <= 1'b0;
            blk_ready_q <= 1'b0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            step_q      <= step_d;
            rd_addr_q   <= rd_addr_d;
            blk_ctr_q   <= blk_ctr_d;
            ctr_ovf_q   <= ctr_ovf_d;
            ld_init_q   <= ld_init_d;
            rnd_en_q    <= rnd_en_d;
            add_init_q  <= add_init_d;
            blk_ready_q <= blk_ready_d;
            rd_en_q     <= rd_en_d;
            busy_q      <= busy_d;
        end
    end

    assign ld_init   = ld_init_q;
    assign rnd_en    = rnd_en_q;
    assign diag      = round_cnt_q[0];
    assign step      = step_q;
    assign add_init  = add_init_q;
    assign blk_ready = blk_ready_q;
    assign rd_addr   = rd_addr_q;
    assign rd_en     = rd_en_q;
    assign blk_ctr   = blk_ctr_q;
    assign ctr_ovf   = ctr_ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_chacha_seq_ctrl.sv
// Bench for chacha_seq_ctrl: table of block scenarios, directed readout/overflow/reset
// sequences, then random inputs against a progress-counter model of the sequencer.
module tb_chacha_seq_ctrl;

    localparam int ROUNDS = 20;
    localparam int STEPS  = 4;
    localparam int NOPS   = ROUNDS * STEPS;

    logic        clk = 1'b0;
    logic        rst, start, hold, cfg_wr, ctr_wr, rd_blk;
    logic [31:0] ctr_in;
    logic        ld_init, rnd_en, diag, add_init, blk_ready, rd_en, ctr_ovf, busy;
    logic [1:0]  step;
    logic [5:0]  rd_addr;
    logic [31:0] blk_ctr;

    always #5 clk = ~clk;

    chacha_seq_ctrl #(.ROUNDS(ROUNDS), .STEPS(STEPS), .AUTO_NEXT(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .cfg_wr(cfg_wr),
        .ctr_wr(ctr_wr), .ctr_in(ctr_in), .rd_blk(rd_blk),
        .ld_init(ld_init), .rnd_en(rnd_en), .diag(diag), .step(step),
        .add_init(add_init), .blk_ready(blk_ready), .rd_addr(rd_addr), .rd_en(rd_en),
        .blk_ctr(blk_ctr), .ctr_ovf(ctr_ovf), .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start = 0; hold = 0; cfg_wr = 0; ctr_wr = 0; rd_blk = 0; ctr_in = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        cyc(); cyc();
        rst = 0;
    endtask

    task automatic wait_ready(input string name);
        int i = 0;
        while (!blk_ready && i < 200) begin cyc(); i++; end
        check(name, 64'(blk_ready), 64'd1);
    endtask

    function automatic logic [47:0] dut_out();
        return {ld_init, rnd_en, diag, step, add_init, blk_ready, rd_en, rd_addr,
                busy, ctr_ovf, blk_ctr};
    endfunction

    // Reference model: a block is a linear progress counter p
    // (0 = load, 1..NOPS = ARX ops, NOPS+1 = final add).
    localparam int MI = 0, MC = 1, MR = 2, MD = 3, MN = 4;
    int          m_mode, m_p, m_addr;
    logic [31:0] m_ctr;
    bit          m_ovf, m_frozen;

    task automatic model_step(input bit r, input bit st, input bit hd, input bit cw,
                              input bit kw, input bit rb, input logic [31:0] ki);
        bit comp, ab, no;
        logic [31:0] nc;
        if (r) begin
            m_mode = MI; m_p = 0; m_addr = 0; m_ctr = 0; m_ovf = 0; m_frozen = 0;
            return;
        end
        comp = (m_mode == MC);
        ab   = comp && (cw || (kw && ki != m_ctr));
        nc   = m_ctr; no = m_ovf;
        if (m_mode == MN) begin
            nc = m_ctr + 32'd1;
            if (m_ctr == 32'hFFFF_FFFF) no = 1;
        end
        if (kw) begin nc = ki; no = 0; end
        m_frozen = 0;
        case (m_mode)
            MI: if (st && !cw) begin m_mode = MC; m_p = 0; end
            MC: begin
                if (ab)                  m_mode = MI;
                else if (hd)             m_frozen = 1;
                else if (m_p == NOPS + 1) m_mode = MR;
                else                     m_p++;
            end
            MR: if (cw) m_mode = MI; else if (rb) begin m_mode = MD; m_addr = 0; end
            MD: begin
                if (cw)              m_mode = MI;
                else if (m_addr == 63) m_mode = MN;
                else                 m_addr++;
            end
            MN: if (!no && !cw) begin m_mode = MC; m_p = 0; end else m_mode = MI;
            default: m_mode = MI;
        endcase
        m_ctr = nc; m_ovf = no;
    endtask

    function automatic logic [47:0] model_out();
        bit comp, inr;
        logic ld, rn, dg, ad, rdy, re, bz;
        logic [1:0] st;
        logic [5:0] ra;
        comp = (m_mode == MC);
        inr  = comp && m_p >= 1 && m_p <= NOPS;
        ld   = comp && m_p == 0 && !m_frozen;
        rn   = inr && !m_frozen;
        st   = inr ? 2'((m_p - 1) % STEPS) : 2'd0;
        dg   = inr ? 1'(((m_p - 1) / STEPS) % 2) : 1'b0;
        ad   = comp && m_p == NOPS + 1 && !m_frozen;
        rdy  = (m_mode == MR);
        re   = (m_mode == MD);
        ra   = re ? 6'(m_addr) : 6'd0;
        bz   = !(m_mode == MI || m_mode == MR);
        return {ld, rn, dg, st, ad, rdy, re, ra, bz, m_ovf, m_ctr};
    endfunction

    typedef struct {
        string name;
        int hold_at, hold_len, cfg_at, ctrw_at;
        int exp_ready, exp_rnd, exp_ld, exp_add;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first_ready, nr, nl, na, bad, n;
        logic [47:0] got;
        // name, hold_at, hold_len, cfg_at, ctrw_at, ready sample, rnd_en, ld_init, add_init
        vecs[0] = '{"plain",       0, 0,  0,  0, 83, 80, 1, 1};
        vecs[1] = '{"hold_r5s2",  24, 7,  0,  0, 90, 80, 1, 1};
        vecs[2] = '{"hold_load",   1, 3,  0,  0, 86, 80, 1, 1};
        vecs[3] = '{"hold_final", 82, 2,  0,  0, 85, 80, 1, 1};
        vecs[4] = '{"cfg_r12",     0, 0, 50,  0,  0, 49, 1, 0};
        vecs[5] = '{"ctrw_abort",  0, 0,  0, 10,  0,  9, 1, 0};
        vecs[6] = '{"hold_cfg",   40, 5, 40,  0,  0, 39, 1, 0};

        rst = 1; idle_inputs();
        for (int v = 0; v < 7; v++) begin
            do_reset();
            check({vecs[v].name, "_reset"}, 64'(dut_out()), 64'd0);
            start = 1; cyc(); start = 0;
            first_ready = 0; nr = 0; nl = 0; na = 0;
            for (int s = 1; s <= 100; s++) begin
                if (ld_init)  nl++;
                if (add_init) na++;
                if (rnd_en) begin
                    check({vecs[v].name, "_diag_step"}, 64'({diag, step}),
                          64'(((nr / STEPS) % 2) * 4 + nr % STEPS));
                    nr++;
                end
                if (blk_ready && first_ready == 0) first_ready = s;
                hold   = (s >= vecs[v].hold_at) && (s < vecs[v].hold_at + vecs[v].hold_len);
                cfg_wr = (s == vecs[v].cfg_at);
                ctr_wr = (s == vecs[v].ctrw_at);
                ctr_in = 32'd7;
                cyc();
            end
            idle_inputs();
            check({vecs[v].name, "_ready_at"}, 64'(first_ready), 64'(vecs[v].exp_ready));
            check({vecs[v].name, "_rnd_cnt"},  64'(nr), 64'(vecs[v].exp_rnd));
            check({vecs[v].name, "_ld_cnt"},   64'(nl), 64'(vecs[v].exp_ld));
            check({vecs[v].name, "_add_cnt"},  64'(na), 64'(vecs[v].exp_add));
        end
        check("ctrw_abort_ctr", 64'(blk_ctr), 64'd0);

        // Full readout followed by the automatic next block.
        do_reset();
        start = 1; cyc(); start = 0;
        wait_ready("rd_ready");
        rd_blk = 1; cyc(); rd_blk = 0;
        bad = 0;
        for (int a = 0; a < 64; a++) begin
            if (!(rd_en && rd_addr == 6'(a) && !blk_ready && busy)) bad++;
            cyc();
        end
        check("rd_sequence", 64'(bad), 64'd0);
        check("next_cycle", 64'({rd_en, busy, ld_init, rd_addr}), 64'({3'b010, 6'd0}));
        cyc();
        check("auto_load", 64'({ld_init, blk_ctr}), 64'({1'b1, 32'd1}));
        n = 1;
        while (!blk_ready && n < 200) begin cyc(); n++; end
        check("auto_ready_at", 64'(n), 64'd83);

        // Counter wrap: sticky overflow and no auto-next.
        do_reset();
        ctr_wr = 1; ctr_in = 32'hFFFF_FFFF; cyc(); ctr_wr = 0;
        check("ctr_load", 64'(blk_ctr), 64'hFFFF_FFFF);
        start = 1; cyc(); start = 0;
        wait_ready("ovf_ready");
        rd_blk = 1; cyc(); rd_blk = 0;
        repeat (64) cyc();
        cyc();
        check("ovf_wrap", 64'({blk_ctr, ctr_ovf, busy, ld_init}), 64'({32'd0, 3'b100}));
        repeat (3) cyc();
        check("ovf_idle", 64'({ctr_ovf, busy, ld_init, blk_ready}), 64'(4'b1000));
        ctr_wr = 1; ctr_in = 32'd5; cyc(); ctr_wr = 0;
        check("ovf_clear", 64'({blk_ctr, ctr_ovf}), 64'({32'd5, 1'b0}));

        // Reset in the middle of a readout.
        do_reset();
        ctr_wr = 1; ctr_in = 32'd9; cyc(); ctr_wr = 0;
        start = 1; cyc(); start = 0;
        wait_ready("rst_ready");
        rd_blk = 1; cyc(); rd_blk = 0;
        repeat (30) cyc();
        check("rst_pre", 64'({rd_en, rd_addr}), 64'({1'b1, 6'd30}));
        rst = 1; cyc(); rst = 0;
        check("rst_in_read", 64'(dut_out()), 64'd0);

        // Random inputs against the model.
        do_reset();
        model_step(1, 0, 0, 0, 0, 0, 32'd0);
        for (int c = 0; c < 6000 && n_fail < 20; c++) begin
            got = dut_out();
            check("random", 64'(got), 64'(model_out()));
            rst    = ($urandom_range(0, 1499) == 0);
            start  = ($urandom_range(0, 3) == 0);
            hold   = ($urandom_range(0, 4) == 0);
            cfg_wr = ($urandom_range(0, 199) == 0);
            ctr_wr = ($urandom_range(0, 299) == 0);
            rd_blk = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       ctr_in = 32'hFFFF_FFFF;
                1:       ctr_in = m_ctr;
                2:       ctr_in = 32'hFFFF_FFFE;
                default: ctr_in = $urandom;
            endcase
            model_step(rst, start, hold, cfg_wr, ctr_wr, rd_blk, ctr_in);
            cyc();
        end
        rst = 0; idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
